gpr_wb_sched: RTL and testbench
===============================

# gpr_wb_sched

Writeback scheduler for the 32×32 general-purpose register file. Shares the register file's single write port between three result producers (ALU, load unit, multiply/divide unit) using round-robin arbitration with valid/ready handshakes. Drives the register file's write enable, address and data from registers, and handles ALU-overflow write suppression. Keeps a pending-write scoreboard that stalls issue on WAW and flags RAW hazards for the decode stage.

## Interface
Parameters:
- NSRC, 3, number of writeback sources; fixed at 3 in this revision.
- DW, 32, data width.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- src_valid  in  3  per-source result valid; bit 0 ALU, bit 1 LOAD, bit 2 MDU.
- src_wr  in  3×5  per-source destination register.
- src_wd  in  3×32  per-source result data.
- alu_ovf  in  1  overflow flag qualifying the ALU source (bit 0) only.
- src_ready  out  3  one-hot grant; a transfer happens when valid and ready are both high.
- gpr_we  out  1  register-file write enable, registered.
- gpr_wr  out  5  register-file write address, registered.
- gpr_wd  out  32  register-file write data, registered.
- ovf_set  out  1  one-cycle pulse requesting the overflow status bit; registered.
- issue_valid  in  1  decode issues an instruction that writes a GPR.
- issue_wr  in  5  destination of the issuing instruction.
- issue_ready  out  1  issue accepted.
- rr1, rr2  in  5  decode source registers.
- hazard  out  1  RAW hazard on rr1 or rr2.

## Operation
- Round-robin pointer `ptr` (0..2) marks the highest-priority source. Search order: ptr, ptr+1, ptr+2 (mod 3). The first source with valid high is granted.
- src_ready is combinational from src_valid and ptr. At most one bit is set. No bit is set when no source is valid.
- After a grant to source k, ptr becomes (k+1) mod 3. Without a grant, ptr is unchanged.
- Commit register, loaded on the granted transfer:
  - gpr_wr and gpr_wd take the granted source's address and data.
  - gpr_we = 1, unless the address is 0, or the grant went to ALU with alu_ovf=1.
  - ovf_set = 1 only for the ALU-with-overflow case.
  - Without a grant, gpr_we=0 and ovf_set=0. gpr_wr and gpr_wd hold their values.
- Scoreboard `pending[31:0]` (bit 0 is always 0):
  - Set: issue_valid && issue_ready && issue_wr≠0 sets pending[issue_wr].
  - Clear: a granted transfer clears pending[src_wr of the granted source]. This includes suppressed (overflow or r0) writes.
  - Set and clear of the same register in the same cycle: set wins.
- issue_ready = (issue_wr==0) || !pending[issue_wr]. This is the WAW stall and is computed from the registered pending value only.
- hazard = (rr1≠0 && pending[rr1]) || (rr2≠0 && pending[rr2]). Combinational from registered pending.

## Timing
- Reset (rst=1 at an edge): gpr_we=0, gpr_wr=0, gpr_wd=0, ovf_set=0, pending=0, ptr=0. While rst is high, src_ready=0 and issue_ready=0.
- Reset mid-operation discards all in-flight grants and pending bits. No write reaches the register file in the cycle after the reset edge.
- Grant in cycle N leads to gpr_we/gpr_wr/gpr_wd valid during N+1. The register file captures the write at the end of N+1.
- Grant/commit throughput: one write per cycle, sustained.
- Pending bit clear: takes effect at the end of N, so hazard drops in N+1. The decode stage's operand read is therefore safe only from N+2; decode must re-check, and the block provides no forwarding.
- A source must hold valid, wr and wd stable until ready is seen. Ungranted sources are never dropped. Starvation bound: 2 cycles of waiting with 3 continuous requesters.

## Configuration
- GPR_WB_TRACE_EN defined: on every cycle where gpr_we=1, the block prints the cycle count, the source index, gpr_wr and gpr_wd through $display. On every ovf_set pulse it prints an "OVF" line.
- Undefined: no trace statements are present. Functional behaviour is identical.

## Structure
- Package wb_pkg holds:
  - SRC_ALU=0, SRC_LOAD=1, SRC_MDU=2
  - NSRC=3
  - REG_AW=5
  - the typedef for a writeback request {wr[4:0], wd[31:0]}
- Sub-module rr_arbiter3 holds the pointer register and the one-hot grant logic. Its inputs are clk, rst and req[2:0]; its output is gnt[2:0].
- The top level holds the commit registers, the scoreboard and the hazard logic.

## Test plan
- Reset, then 3 idle cycles -> all outputs 0, pending=0, issue_ready=1 for issue_wr=5.
- ALU only: valid, wr=8, wd=0x12345678 in cycle N -> src_ready=001 in N; gpr_we=1, gpr_wr=8, gpr_wd=0x12345678 in N+1.
- All three sources valid continuously for 6 cycles, ptr=0 -> grants 001, 010, 100, 001, 010, 100.
- ALU wr=3 with alu_ovf=1 -> gpr_we=0 and ovf_set=1 in N+1. Pending[3] cleared. LOAD wr=0 -> gpr_we=0 and ovf_set=0.
- Issue wr=9, then issue wr=9 again -> issue_ready=0 on the second. Decode rr1=9 -> hazard=1. LOAD wr=9 granted in N -> hazard=0 and issue_ready=1 in N+1.
- Issue wr=4 in the same cycle a granted MDU writes wr=4 -> pending[4] ends at 1. Assert rst during a grant -> gpr_we=0 in the next cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the GPR writeback scheduler.
package wb_pkg;

  localparam int unsigned SRC_ALU  = 0;
  localparam int unsigned SRC_LOAD = 1;
  localparam int unsigned SRC_MDU  = 2;
  localparam int unsigned NSRC     = 3;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NREGS    = 32;

  typedef struct packed {
    logic [REG_AW-1:0] wr;
    logic [DATA_W-1:0] wd;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: pointer register plus one-hot combinational grant.
module rr_arbiter3 (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] gnt
);

  logic [1:0] ptr_q, ptr_d;
  logic [2:0] idx;
  logic       found;

  // Search from ptr upward (mod 3); first requester wins; nothing granted in reset.
  always_comb begin
    gnt   = 3'b000;
    found = 1'b0;
    idx   = 3'd0;
    for (int unsigned i = 0; i < 3; i++) begin
      idx = 3'({1'b0, ptr_q}) + 3'(i);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!found && !rst && req[2'(idx)]) begin
        gnt[2'(idx)] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    unique case (1'b1)
      gnt[0]:  ptr_d = 2'd1;
      gnt[1]:  ptr_d = 2'd2;
      gnt[2]:  ptr_d = 2'd0;
      default: ptr_d = ptr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 2'd0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/gpr_wb_sched.sv
// GPR write-port scheduler: round-robin commit, overflow suppression, WAW/RAW scoreboard.
// Optional trace of committed writes when GPR_WB_TRACE_EN is defined.
module gpr_wb_sched
  import wb_pkg::wb_req_t, wb_pkg::REG_AW, wb_pkg::NREGS, wb_pkg::SRC_ALU;
#(
  parameter int unsigned NSRC = 3,
  parameter int unsigned DW   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NSRC-1:0]            src_valid,
  input  logic [NSRC-1:0][REG_AW-1:0] src_wr,
  input  logic [NSRC-1:0][DW-1:0]    src_wd,
  input  logic                       alu_ovf,
  output logic [NSRC-1:0]            src_ready,
  output logic                       gpr_we,
  output logic [REG_AW-1:0]          gpr_wr,
  output logic [DW-1:0]              gpr_wd,
  output logic                       ovf_set,
  input  logic                       issue_valid,
  input  logic [REG_AW-1:0]          issue_wr,
  output logic                       issue_ready,
  input  logic [REG_AW-1:0]          rr1,
  input  logic [REG_AW-1:0]          rr2,
  output logic                       hazard
);

  logic [2:0]       gnt;
  logic             grant;
  wb_req_t          sel;
  logic [1:0]       sel_idx;
  logic             sel_ovf;
  logic             gpr_we_q, ovf_set_q;
  logic [REG_AW-1:0] gpr_wr_q;
  logic [DW-1:0]    gpr_wd_q;
  logic [NREGS-1:0] pend_q, pend_d;

  rr_arbiter3 u_arb (
    .clk (clk),
    .rst (rst),
    .req (src_valid),
    .gnt (gnt)
  );

  assign src_ready = gnt;
  assign grant     = |gnt;

  // Mux out the granted source's payload.
  always_comb begin
    sel     = '0;
    sel_idx = 2'd0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (gnt[i]) begin
        sel.wr  = src_wr[i];
        sel.wd  = src_wd[i];
        sel_idx = 2'(i);
      end
    end
    sel_ovf = gnt[SRC_ALU] && alu_ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpr_we_q  <= 1'b0;
      gpr_wr_q  <= '0;
      gpr_wd_q  <= '0;
      ovf_set_q <= 1'b0;
    end else if (grant) begin
      gpr_we_q  <= (sel.wr != '0) && !sel_ovf;
      gpr_wr_q  <= sel.wr;
      gpr_wd_q  <= sel.wd;
      ovf_set_q <= sel_ovf;
    end else begin
      gpr_we_q  <= 1'b0;
      ovf_set_q <= 1'b0;
    end
  end

  assign gpr_we  = gpr_we_q;
  assign gpr_wr  = gpr_wr_q;
  assign gpr_wd  = gpr_wd_q;
  assign ovf_set = ovf_set_q;

  // Scoreboard: clear on any granted transfer, then set on accepted issue (set wins).
  always_comb begin
    pend_d = pend_q;
    if (grant) pend_d[sel.wr] = 1'b0;
    if (issue_valid && issue_ready && (issue_wr != '0)) pend_d[issue_wr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign issue_ready = !rst && ((issue_wr == '0) || !pend_q[issue_wr]);
  assign hazard      = ((rr1 != '0) && pend_q[rr1]) || ((rr2 != '0) && pend_q[rr2]);

`ifdef GPR_WB_TRACE_EN
  logic [31:0] cyc_q;
  logic [1:0]  src_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      src_q <= 2'd0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (grant) src_q <= sel_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && gpr_we_q)
      $display("WB cyc=%0d src=%0d wr=%0d wd=%08h", cyc_q, src_q, gpr_wr_q, gpr_wd_q);
    if (!rst && ovf_set_q)
      $display("OVF cyc=%0d wr=%0d", cyc_q, gpr_wr_q);
  end
`else
  logic unused_sel_idx;
  assign unused_sel_idx = ^sel_idx;
`endif

endmodule

// File: tb/tb_gpr_wb_sched.sv
// Self-checking bench for gpr_wb_sched: queue/array reference model plus directed literals.
module tb_gpr_wb_sched;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       src_valid;
  logic [2:0][4:0]  src_wr;
  logic [2:0][31:0] src_wd;
  logic             alu_ovf;
  logic [2:0]       src_ready;
  logic             gpr_we;
  logic [4:0]       gpr_wr;
  logic [31:0]      gpr_wd;
  logic             ovf_set;
  logic             issue_valid;
  logic [4:0]       issue_wr;
  logic             issue_ready;
  logic [4:0]       rr1, rr2;
  logic             hazard;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  gpr_wb_sched #(.NSRC(3), .DW(32)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_wr(src_wr), .src_wd(src_wd),
    .alu_ovf(alu_ovf), .src_ready(src_ready), .gpr_we(gpr_we), .gpr_wr(gpr_wr),
    .gpr_wd(gpr_wd), .ovf_set(ovf_set), .issue_valid(issue_valid), .issue_wr(issue_wr),
    .issue_ready(issue_ready), .rr1(rr1), .rr2(rr2), .hazard(hazard)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state (values visible on the outputs this cycle).
  int          m_ptr = 0;
  bit [31:0]   m_pend = '0;
  bit          m_we = 0, m_ovf = 0;
  bit [4:0]    m_wr = '0;
  bit [31:0]   m_wd = '0;

  always @(negedge clk) begin
    int        g;
    bit [2:0]  e_ready;
    bit        e_ir, e_hz;
    if (started) begin
      g = -1;
      if (!rst)
        for (int k = 0; k < 3; k++)
          if (g < 0 && src_valid[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
      e_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
      e_ir = !rst && (issue_wr == 0 || !m_pend[issue_wr]);
      e_hz = (rr1 != 0 && m_pend[rr1]) || (rr2 != 0 && m_pend[rr2]);

      chk("m_src_ready", 32'(src_ready), 32'(e_ready));
      chk("m_gpr_we", 32'(gpr_we), 32'(m_we));
      chk("m_ovf_set", 32'(ovf_set), 32'(m_ovf));
      chk("m_gpr_wr", 32'(gpr_wr), 32'(m_wr));
      chk("m_gpr_wd", gpr_wd, m_wd);
      chk("m_issue_ready", 32'(issue_ready), 32'(e_ir));
      chk("m_hazard", 32'(hazard), 32'(e_hz));

      // Advance the model to what the coming edge must produce.
      if (rst) begin
        m_ptr = 0; m_pend = '0; m_we = 0; m_ovf = 0; m_wr = '0; m_wd = '0;
      end else begin
        if (g >= 0) begin
          m_pend[src_wr[g]] = 1'b0;
          m_wr  = src_wr[g];
          m_wd  = src_wd[g];
          m_ovf = (g == 0) && alu_ovf;
          m_we  = (src_wr[g] != 0) && !m_ovf;
          m_ptr = (g + 1) % 3;
        end else begin
          m_we = 0; m_ovf = 0;
        end
        if (issue_valid && e_ir && issue_wr != 0) m_pend[issue_wr] = 1'b1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    src_valid = 3'b000; alu_ovf = 1'b0; issue_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; src_valid = '0; src_wr = '0; src_wd = '0; alu_ovf = 1'b0;
    issue_valid = 1'b0; issue_wr = 5'd5; rr1 = '0; rr2 = '0;
    @(posedge clk); #1;
    started = 1'b1;
    src_valid = 3'b111;
    @(negedge clk);
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    chk("rst_issue_ready", 32'(issue_ready), 32'd0);
    tick;
    rst = 1'b0; idle;
    tick; tick; tick;
    @(negedge clk);
    chk("idle_we", 32'(gpr_we), 32'd0);
    chk("idle_wd", gpr_wd, 32'd0);
    chk("idle_issue_ready_r5", 32'(issue_ready), 32'd1);

    // Single ALU write.
    tick;
    src_valid = 3'b001; src_wr[0] = 5'd8; src_wd[0] = 32'h12345678;
    @(negedge clk);
    chk("alu_ready", 32'(src_ready), 32'b001);
    tick; idle;
    @(negedge clk);
    chk("alu_we", 32'(gpr_we), 32'd1);
    chk("alu_wr", 32'(gpr_wr), 32'd8);
    chk("alu_wd", gpr_wd, 32'h12345678);

    // One MDU grant brings ptr back to 0, then three continuous requesters.
    tick;
    src_valid = 3'b100; src_wr[2] = 5'd3; src_wd[2] = 32'hCAFE0002;
    tick;
    src_valid = 3'b111;
    src_wr[0] = 5'd1; src_wd[0] = 32'hA0;
    src_wr[1] = 5'd2; src_wd[1] = 32'hB1;
    src_wr[2] = 5'd3; src_wd[2] = 32'hC2;
    for (int c = 0; c < 6; c++) begin
      logic [2:0] exp_g;
      exp_g = (c % 3 == 0) ? 3'b001 : (c % 3 == 1) ? 3'b010 : 3'b100;
      @(negedge clk);
      chk("rr_grant", 32'(src_ready), 32'(exp_g));
      if (c > 0) chk("rr_wd", gpr_wd, (c % 3 == 1) ? 32'hA0 : (c % 3 == 2) ? 32'hB1 : 32'hC2);
      tick;
    end
    idle;

    // ALU overflow suppresses the write but clears pending; r0 writes are suppressed.
    issue_valid = 1'b1; issue_wr = 5'd3;
    tick; idle;
    src_valid = 3'b001; src_wr[0] = 5'd3; src_wd[0] = 32'hDEAD; alu_ovf = 1'b1;
    issue_wr = 5'd3;
    @(negedge clk);
    chk("ovf_pending3", 32'(issue_ready), 32'd0);
    tick; idle;
    src_valid = 3'b010; src_wr[1] = 5'd0; src_wd[1] = 32'h5555;
    @(negedge clk);
    chk("ovf_we", 32'(gpr_we), 32'd0);
    chk("ovf_set", 32'(ovf_set), 32'd1);
    chk("ovf_cleared3", 32'(issue_ready), 32'd1);
    tick; idle;
    @(negedge clk);
    chk("r0_we", 32'(gpr_we), 32'd0);
    chk("r0_ovf", 32'(ovf_set), 32'd0);

    // WAW stall and RAW hazard on r9.
    tick;
    issue_valid = 1'b1; issue_wr = 5'd9;
    tick;
    rr1 = 5'd9;
    @(negedge clk);
    chk("waw_stall", 32'(issue_ready), 32'd0);
    chk("raw_hazard", 32'(hazard), 32'd1);
    tick;
    issue_valid = 1'b0;
    src_valid = 3'b010; src_wr[1] = 5'd9; src_wd[1] = 32'h99;
    @(negedge clk);
    chk("raw_hold", 32'(hazard), 32'd1);
    tick; idle;
    @(negedge clk);
    chk("raw_clear", 32'(hazard), 32'd0);
    chk("waw_clear", 32'(issue_ready), 32'd1);

    // Same-cycle set and clear of r4: set wins.
    tick;
    rr1 = 5'd0; rr2 = 5'd4;
    issue_valid = 1'b1; issue_wr = 5'd4;
    src_valid = 3'b100; src_wr[2] = 5'd4; src_wd[2] = 32'h44;
    tick; idle;
    @(negedge clk);
    chk("setwins_ready", 32'(issue_ready), 32'd0);
    chk("setwins_hazard", 32'(hazard), 32'd1);

    // Reset during a grant discards the write and all pending bits.
    tick;
    issue_valid = 1'b1; issue_wr = 5'd12;
    tick; idle;
    rst = 1'b1;
    src_valid = 3'b001; src_wr[0] = 5'd7; src_wd[0] = 32'h77;
    tick;
    rst = 1'b0; idle; issue_wr = 5'd12;
    @(negedge clk);
    chk("rst_we", 32'(gpr_we), 32'd0);
    chk("rst_pend12", 32'(issue_ready), 32'd1);
    chk("rst_hazard4", 32'(hazard), 32'd0);

    // Mixed traffic checked against the model every cycle.
    for (int c = 0; c < 40; c++) begin
      tick;
      src_valid   = 3'($urandom_range(0, 7));
      for (int s = 0; s < 3; s++) begin
        src_wr[s] = 5'($urandom_range(0, 15));
        src_wd[s] = $urandom;
      end
      alu_ovf     = ($urandom_range(0, 3) == 0);
      issue_valid = $urandom_range(0, 1) == 1;
      issue_wr    = 5'($urandom_range(0, 15));
      rr1         = 5'($urandom_range(0, 15));
      rr2         = 5'($urandom_range(0, 15));
    end
    tick; idle;
    tick; tick;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
